// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS pipeline MEM stage.
package mips_pkg;

    localparam int WORD_W         = 32;
    localparam int REG_ADDR_W     = 5;
    localparam int DMEM_WORDS_DEF = 64;
    localparam int ADDR_BASE_DEF  = 1024;
    localparam int ACCESS_LAT_DEF = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_fault;
        logic [WORD_W-1:0]     pc;
        logic [WORD_W-1:0]     alu_result;
        logic [WORD_W-1:0]     mem_result;
        logic [REG_ADDR_W-1:0] dest;
    } mem_wb_t;

    // Keeps the wait counter at least one bit wide when ACCESS_LAT is 0.
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
module data_memory
    import mips_pkg::*;
#(
    parameter int WORDS = DMEM_WORDS_DEF,
    parameter int AW    = $clog2(DMEM_WORDS_DEF)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: wait-state FSM that freezes upstream, data memory, MEM/WB register.
// Optional macro DMEM_BOUNDS_CHECK_EN adds address range/alignment checking and mem_fault.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DMEM_WORDS = DMEM_WORDS_DEF,
    parameter int ACCESS_LAT = ACCESS_LAT_DEF,
    parameter int ADDR_BASE  = ADDR_BASE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_en_in,
    input  logic                  MEM_R_EN_in,
    input  logic                  MEM_W_EN_in,
    input  logic [WORD_W-1:0]     PC_in,
    input  logic [WORD_W-1:0]     ALU_result_in,
    input  logic [WORD_W-1:0]     ST_val_in,
    input  logic [REG_ADDR_W-1:0] Dest_in,
    output logic                  WB_en,
    output logic                  MEM_R_EN,
    output logic [WORD_W-1:0]     PC,
    output logic [WORD_W-1:0]     ALU_result,
    output logic [WORD_W-1:0]     MEM_result,
    output logic [REG_ADDR_W-1:0] Dest,
    output logic                  freeze,
    output logic                  mem_fault
);

    localparam int AW    = $clog2(DMEM_WORDS);
    localparam int CNT_W = cnt_width(ACCESS_LAT);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              complete;
    logic              mem_op, is_load, is_store, addr_ok, dmem_we;
    logic [WORD_W-1:0] addr_off, rdata;
    logic [AW-1:0]     word_idx;
    mem_wb_t           wb_q;

    assign mem_op   = MEM_R_EN_in | MEM_W_EN_in;
    assign is_store = MEM_W_EN_in;
    assign is_load  = MEM_R_EN_in & ~MEM_W_EN_in;
    assign addr_off = ALU_result_in - WORD_W'(ADDR_BASE);
    assign word_idx = AW'(addr_off >> 2);

`ifdef DMEM_BOUNDS_CHECK_EN
    // Offset compare is only meaningful once addr >= base, so it never wraps.
    assign addr_ok = (ALU_result_in >= WORD_W'(ADDR_BASE)) &&
                     (addr_off < WORD_W'(4 * DMEM_WORDS)) &&
                     (ALU_result_in[1:0] == 2'b00);
`else
    assign addr_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (mem_op && (ACCESS_LAT > 0)) begin
                state_d = WAIT;
                cnt_d   = CNT_W'(ACCESS_LAT - 1);
            end
            WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                  else             state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // complete marks the edge on which inputs are sampled and the access happens.
    always_comb begin
        freeze   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: if (mem_op && (ACCESS_LAT > 0)) freeze = 1'b1;
                  else                            complete = 1'b1;
            WAIT: if (cnt_q != '0) freeze = 1'b1;
                  else             complete = 1'b1;
            default: complete = 1'b0;
        endcase
        if (rst) begin
            freeze   = 1'b0;
            complete = 1'b0;
        end
    end

    assign dmem_we = complete & is_store & addr_ok;

    data_memory #(.WORDS(DMEM_WORDS), .AW(AW)) u_dmem (
        .clk   (clk),
        .we    (dmem_we),
        .addr  (word_idx),
        .wdata (ST_val_in),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= '0;
        end else if (complete) begin
            wb_q.wb_en      <= WB_en_in;
            wb_q.mem_r_en   <= is_load;
            wb_q.mem_fault  <= mem_op & ~addr_ok;
            wb_q.pc         <= PC_in;
            wb_q.alu_result <= ALU_result_in;
            wb_q.mem_result <= (is_load && addr_ok) ? rdata : '0;
            wb_q.dest       <= Dest_in;
        end else begin
            wb_q.wb_en     <= 1'b0;
            wb_q.mem_r_en  <= 1'b0;
            wb_q.mem_fault <= 1'b0;
        end
    end

    assign WB_en      = wb_q.wb_en;
    assign MEM_R_EN   = wb_q.mem_r_en;
    assign PC         = wb_q.pc;
    assign ALU_result = wb_q.alu_result;
    assign MEM_result = wb_q.mem_result;
    assign Dest       = wb_q.dest;
    assign mem_fault  = wb_q.mem_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expectations, a negedge monitor checks them.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] PC_in, ALU_result_in, ST_val_in;
    logic [4:0]  Dest_in;
    logic        WB_en, MEM_R_EN, freeze, mem_fault;
    logic [31:0] PC, ALU_result, MEM_result;
    logic [4:0]  Dest;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] mres;
        logic [4:0]  dest;
        logic        r_en;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mem_stage #(.DMEM_WORDS(64), .ACCESS_LAT(2), .ADDR_BASE(1024)) dut (
        .clk(clk), .rst(rst),
        .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .PC_in(PC_in), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in), .Dest_in(Dest_in),
        .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .PC(PC), .ALU_result(ALU_result),
        .MEM_result(MEM_result), .Dest(Dest), .freeze(freeze), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write-back-enabled MEM/WB output must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && WB_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(WB_en), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pc",         64'(PC),         64'(e.pc));
                chk("alu_result", 64'(ALU_result), 64'(e.alu));
                chk("mem_result", 64'(MEM_result), 64'(e.mres));
                chk("dest",       64'(Dest),       64'(e.dest));
                chk("mem_r_en",   64'(MEM_R_EN),   64'(e.r_en));
                chk("mem_fault",  64'(mem_fault),  64'(e.fault));
            end
        end
    end

    task automatic drive(input logic wb, input logic r, input logic w, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] st, input logic [4:0] dst);
        WB_en_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
        PC_in = pc; ALU_result_in = alu; ST_val_in = st; Dest_in = dst;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the completion edge.
    task automatic do_op(input logic r, input logic w, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] st, input logic [4:0] dst,
                         input logic [31:0] exp_mres, input logic exp_fault, input int exp_frz);
        exp_t e;
        int   n;
        drive(1'b1, r, w, pc, alu, st, dst);
        e.pc = pc; e.alu = alu; e.mres = exp_mres; e.dest = dst;
        e.r_en = r & ~w; e.fault = exp_fault;
        exp_q.push_back(e);
        n = 0;
        forever begin
            @(negedge clk);
            if (!freeze) break;
            if (n > 0) chk("bubble_wb_en", 64'(WB_en), 64'd0);
            n++;
            if (n > 20) begin
                chk("freeze_timeout", 64'(n), 64'(exp_frz));
                break;
            end
        end
        chk("freeze_cycles", 64'(n), 64'(exp_frz));
        @(posedge clk); #1;
        chk("wb_timing", 64'(WB_en), 64'd1);
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_en",  64'(WB_en),      64'd0);
        chk("rst_r_en",   64'(MEM_R_EN),   64'd0);
        chk("rst_pc",     64'(PC),         64'd0);
        chk("rst_alu",    64'(ALU_result), 64'd0);
        chk("rst_mres",   64'(MEM_result), 64'd0);
        chk("rst_dest",   64'(Dest),       64'd0);
        chk("rst_freeze", 64'(freeze),     64'd0);
        chk("rst_fault",  64'(mem_fault),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU pass-through, no freeze, one-cycle latency
        do_op(1'b0, 1'b0, 32'h100, 32'h1234, 32'h0, 5'd5, 32'h0, 1'b0, 0);
        // Store then back-to-back load of the same word
        do_op(1'b0, 1'b1, 32'h104, 32'd1028, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 2);
        do_op(1'b1, 1'b0, 32'h108, 32'd1028, 32'h0, 5'd7, 32'hDEADBEEF, 1'b0, 2);
        idle_cycle();
        do_op(1'b1, 1'b0, 32'h10C, 32'd1028, 32'h0, 5'd8, 32'hDEADBEEF, 1'b0, 2);
        // R_EN and W_EN together behave as a store
        do_op(1'b1, 1'b1, 32'h110, 32'd1032, 32'd7, 5'd9, 32'h0, 1'b0, 2);
        do_op(1'b1, 1'b0, 32'h114, 32'd1032, 32'h0, 5'd10, 32'd7, 1'b0, 2);
        // Top word of memory
        do_op(1'b0, 1'b1, 32'h118, 32'd1276, 32'h77, 5'd0, 32'h0, 1'b0, 2);
        do_op(1'b1, 1'b0, 32'h11C, 32'd1276, 32'h0, 5'd11, 32'h77, 1'b0, 2);
        do_op(1'b0, 1'b0, 32'h120, 32'hCAFE, 32'h0, 5'd31, 32'h0, 1'b0, 0);

        // Reset while a store is waiting must abort it
        do_op(1'b0, 1'b1, 32'h124, 32'd1036, 32'h1111, 5'd0, 32'h0, 1'b0, 2);
        drive(1'b1, 1'b0, 1'b1, 32'h128, 32'd1036, 32'h2222, 5'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_wb_en",  64'(WB_en),      64'd0);
        chk("midrst_freeze", 64'(freeze),     64'd0);
        chk("midrst_alu",    64'(ALU_result), 64'd0);
        chk("midrst_mres",   64'(MEM_result), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle();
        do_op(1'b1, 1'b0, 32'h12C, 32'd1036, 32'h0, 5'd12, 32'h1111, 1'b0, 2);

`ifdef DMEM_BOUNDS_CHECK_EN
        do_op(1'b0, 1'b1, 32'h130, 32'd1024, 32'hAAAA, 5'd0, 32'h0, 1'b0, 2);
        do_op(1'b1, 1'b0, 32'h134, 32'd1000, 32'h0, 5'd13, 32'h0, 1'b1, 2);
        do_op(1'b0, 1'b1, 32'h138, 32'd1026, 32'h5555, 5'd0, 32'h0, 1'b1, 2);
        do_op(1'b1, 1'b0, 32'h13C, 32'd1024, 32'h0, 5'd14, 32'hAAAA, 1'b0, 2);
        do_op(1'b1, 1'b0, 32'h140, 32'd1280, 32'h0, 5'd15, 32'h0, 1'b1, 2);
`endif

        idle_cycle();
        idle_cycle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
